// File: rtl/pe_vec.sv
// pe_vec: multi-lane signed fixed-point processing element for the systolic array.
// Each of LANES lanes reduces a window of operand beats in MAC, MAX or SUM mode.
// The result is saturated to DATA_WIDTH and emitted with a one-cycle valid pulse.
// Operands and control are forwarded to the neighbouring PE through one register stage.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   valid_i, last_i      beat qualifier and end-of-window marker
//   clr_i                synchronous window clear
//   mode_i               00 MAC, 01 MAX, 10 SUM, 11 reserved (latched on the opening beat)
//   srca_i, srcb_i       packed per-lane operands, lane k at [k*DW +: DW]
//   srca_o, srcb_o       operands delayed one cycle
//   valid_o, last_o,
//   clr_o, mode_o        control delayed one cycle
//   psum_o, ovf_o        saturated per-lane result and per-lane clamp flag
//   psum_valid_o         one-cycle pulse marking a new psum_o
module pe_vec #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int LANES      = 4,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        valid_i,
    input  logic                        last_i,
    input  logic                        clr_i,
    input  logic [1:0]                  mode_i,
    input  logic [LANES*DATA_WIDTH-1:0] srca_i,
    input  logic [LANES*DATA_WIDTH-1:0] srcb_i,
    output logic [LANES*DATA_WIDTH-1:0] srca_o,
    output logic [LANES*DATA_WIDTH-1:0] srcb_o,
    output logic                        valid_o,
    output logic                        last_o,
    output logic                        clr_o,
    output logic [1:0]                  mode_o,
    output logic [LANES*DATA_WIDTH-1:0] psum_o,
    output logic                        psum_valid_o,
    output logic [LANES-1:0]            ovf_o
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = ACC_WIDTH;

    localparam logic [1:0] MODE_MAC = 2'b00;
    localparam logic [1:0] MODE_MAX = 2'b01;
    localparam logic [1:0] MODE_SUM = 2'b10;

    // Clamping is needed exactly when the bits above the DW-1 sign bit are not
    // all copies of it.
    function automatic logic sat_ovf(input logic signed [AW-1:0] v);
        logic [AW-DW:0] top;
        top = v[AW-1:DW-1];
        return !((&top) || !(|top));
    endfunction

    function automatic logic [DW-1:0] sat_val(input logic signed [AW-1:0] v);
        if (!sat_ovf(v))
            return v[DW-1:0];
        else if (v[AW-1])
            return {1'b1, {(DW-1){1'b0}}};
        else
            return {1'b0, {(DW-1){1'b1}}};
    endfunction

    logic signed [AW-1:0]      w_mprod_p0 [LANES];
    logic signed [AW-1:0]      r_mprod_p1 [LANES];
    logic signed [AW-1:0]      w_aext_p1  [LANES];
    logic signed [AW-1:0]      w_base_p1  [LANES];
    logic signed [AW-1:0]      w_acc_nxt  [LANES];
    logic signed [AW-1:0]      r_acc_p2   [LANES];

    logic [LANES*DW-1:0]       r_srca_p1;
    logic [LANES*DW-1:0]       r_srcb_p1;
    logic                      r_vld_p1;
    logic                      r_last_p1;
    logic                      r_clr_p1;
    logic [1:0]                r_mode_p1;

    logic                      r_open_p2;
    logic [1:0]                r_mode_p2;
    logic [LANES*DW-1:0]       r_psum_p2;
    logic [LANES-1:0]          r_ovf_p2;
    logic                      r_psum_vld_p2;

    logic                      w_open_p1;
    logic [1:0]                w_mode_p1;

    // ---- Stage 0 -> 1: full-precision product, floored by the arithmetic shift.
    // Both product and raw srca are carried forward because the mode that selects
    // between them is only known once the window's latched mode is resolved.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [AW-1:0] w_aext_p0;
        logic signed [AW-1:0] w_bext_p0;
        assign w_aext_p0     = {{(AW-DW){srca_i[k*DW+DW-1]}}, srca_i[k*DW +: DW]};
        assign w_bext_p0     = {{(AW-DW){srcb_i[k*DW+DW-1]}}, srcb_i[k*DW +: DW]};
        assign w_mprod_p0[k] = (w_aext_p0 * w_bext_p0) >>> FRAC_BITS;

        assign w_aext_p1[k]  = {{(AW-DW){r_srca_p1[k*DW+DW-1]}}, r_srca_p1[k*DW +: DW]};
        assign w_base_p1[k]  = r_clr_p1 ? '0 : r_acc_p2[k];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_srca_p1 <= '0;
            r_srcb_p1 <= '0;
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
            r_clr_p1  <= 1'b0;
            r_mode_p1 <= 2'b00;
            for (int k = 0; k < LANES; k++) r_mprod_p1[k] <= '0;
        end else begin
            r_srca_p1 <= srca_i;
            r_srcb_p1 <= srcb_i;
            r_vld_p1  <= valid_i;
            r_last_p1 <= last_i;
            r_clr_p1  <= clr_i;
            r_mode_p1 <= mode_i;
            for (int k = 0; k < LANES; k++) r_mprod_p1[k] <= w_mprod_p0[k];
        end
    end

    // ---- Stage 1 -> 2: accumulate. A clear is applied before the beat, so a
    // beat arriving with clr is an opening beat and loads rather than adds.
    always_comb begin
        w_open_p1 = r_vld_p1 && (!r_open_p2 || r_clr_p1);
        w_mode_p1 = w_open_p1 ? r_mode_p1 : r_mode_p2;
        for (int k = 0; k < LANES; k++) begin
            w_acc_nxt[k] = w_base_p1[k];
            if (r_vld_p1) begin
                case (w_mode_p1)
                    MODE_MAC: w_acc_nxt[k] = w_open_p1 ? r_mprod_p1[k]
                                                       : w_base_p1[k] + r_mprod_p1[k];
                    MODE_SUM: w_acc_nxt[k] = w_open_p1 ? w_aext_p1[k]
                                                       : w_base_p1[k] + w_aext_p1[k];
                    MODE_MAX: w_acc_nxt[k] = (w_open_p1 || (w_aext_p1[k] > w_base_p1[k]))
                                             ? w_aext_p1[k] : w_base_p1[k];
                    // Reserved mode opens at zero so its window reports 0.
                    default:  w_acc_nxt[k] = w_open_p1 ? '0 : w_base_p1[k];
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_open_p2     <= 1'b0;
            r_mode_p2     <= 2'b00;
            r_psum_p2     <= '0;
            r_ovf_p2      <= '0;
            r_psum_vld_p2 <= 1'b0;
            for (int k = 0; k < LANES; k++) r_acc_p2[k] <= '0;
        end else begin
            for (int k = 0; k < LANES; k++) r_acc_p2[k] <= w_acc_nxt[k];
            if (r_vld_p1)
                r_open_p2 <= !r_last_p1;
            else if (r_clr_p1)
                r_open_p2 <= 1'b0;
            if (w_open_p1)
                r_mode_p2 <= r_mode_p1;
            r_psum_vld_p2 <= r_vld_p1 && r_last_p1;
            if (r_vld_p1 && r_last_p1) begin
                for (int k = 0; k < LANES; k++) begin
                    r_psum_p2[k*DW +: DW] <= sat_val(w_acc_nxt[k]);
                    r_ovf_p2[k]           <= sat_ovf(w_acc_nxt[k]);
                end
            end
        end
    end

    assign srca_o       = r_srca_p1;
    assign srcb_o       = r_srcb_p1;
    assign valid_o      = r_vld_p1;
    assign last_o       = r_last_p1;
    assign clr_o        = r_clr_p1;
    assign mode_o       = r_mode_p1;
    assign psum_o       = r_psum_p2;
    assign psum_valid_o = r_psum_vld_p2;
    assign ovf_o        = r_ovf_p2;

endmodule

// File: tb/tb_pe_vec.sv
// Testbench for pe_vec (DW=16, FRAC=8, LANES=4): directed windows with
// hand-computed results pushed into a scoreboard queue; a monitor pops on each
// psum_valid_o pulse and checks value, overflow flags and arrival cycle.
module tb_pe_vec;

    localparam logic [1:0] MAC = 2'b00;
    localparam logic [1:0] MAX = 2'b01;
    localparam logic [1:0] SUM = 2'b10;
    localparam logic [1:0] RSV = 2'b11;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0, last_i = 1'b0, clr_i = 1'b0;
    logic [1:0]  mode_i = 2'b00;
    logic [63:0] srca_i = '0, srcb_i = '0;
    logic [63:0] srca_o, srcb_o, psum_o;
    logic        valid_o, last_o, clr_o, psum_valid_o;
    logic [1:0]  mode_o;
    logic [3:0]  ovf_o;

    always #5 clk = ~clk;

    pe_vec #(.DATA_WIDTH(16), .FRAC_BITS(8), .LANES(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .last_i(last_i),
        .clr_i(clr_i), .mode_i(mode_i), .srca_i(srca_i), .srcb_i(srcb_i),
        .srca_o(srca_o), .srcb_o(srcb_o), .valid_o(valid_o), .last_o(last_o),
        .clr_o(clr_o), .mode_o(mode_o), .psum_o(psum_o),
        .psum_valid_o(psum_valid_o), .ovf_o(ovf_o)
    );

    typedef struct {
        logic [63:0] psum;
        logic [3:0]  ovf;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    logic fwd_en = 1'b0;

    logic [63:0] cap_a, cap_b;
    logic        cap_v, cap_l, cap_c;
    logic [1:0]  cap_m;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        cap_a <= srca_i;
        cap_b <= srcb_i;
        cap_v <= valid_i;
        cap_l <= last_i;
        cap_c <= clr_i;
        cap_m <= mode_i;
    end

    function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic beat(input logic v, input logic l, input logic c, input logic [1:0] m,
                        input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        valid_i  = v;
        last_i   = l;
        clr_i    = c;
        mode_i   = m;
        srca_i   = a;
        srcb_i   = b;
        last_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) beat(1'b0, 1'b0, 1'b0, MAC, '0, '0);
    endtask

    // Result of a window whose last beat was just issued: two register stages later.
    task automatic expect_res(input logic [63:0] p, input logic [3:0] o);
        exp_t e;
        e.psum = p;
        e.ovf  = o;
        e.cyc  = last_cyc + 2;
        q.push_back(e);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst_i && psum_valid_o === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_psum_valid cyc=%0d psum=%h ovf=%b", cyc, psum_o, ovf_o);
            end else begin
                mon_e = q.pop_front();
                if (psum_o !== mon_e.psum || ovf_o !== mon_e.ovf || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL psum got=%h/%b@%0d want=%h/%b@%0d",
                             psum_o, ovf_o, cyc, mon_e.psum, mon_e.ovf, mon_e.cyc);
                end
            end
        end
    end

    // Forwarding monitor: outputs equal inputs sampled on the previous edge.
    always @(negedge clk) begin
        if (fwd_en) begin
            checks++;
            if ({srca_o, srcb_o, valid_o, last_o, clr_o, mode_o} !==
                {cap_a, cap_b, cap_v, cap_l, cap_c, cap_m}) begin
                errors++;
                $display("FAIL forward cyc=%0d got=%h/%h/%b%b%b%b want=%h/%h/%b%b%b%b",
                         cyc, srca_o, srcb_o, valid_o, last_o, clr_o, mode_o,
                         cap_a, cap_b, cap_v, cap_l, cap_c, cap_m);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_psum", psum_o, '0);
        chk("reset_src", srca_o | srcb_o, '0);
        chk("reset_ctl", 64'({valid_o, last_o, clr_o, mode_o, psum_valid_o, ovf_o}), '0);
        rst_i = 1'b0;
        idle(2);
        fwd_en = 1'b1;

        // MAC: lane0 a=b, lane1 b=-256
        beat(1, 0, 0, MAC, pk(256, 256, 0, 0),   pk(256, -256, 0, 0));
        beat(1, 0, 0, MAC, pk(512, 512, 0, 0),   pk(512, -256, 0, 0));
        beat(1, 0, 0, MAC, pk(768, 768, 0, 0),   pk(768, -256, 0, 0));
        beat(1, 1, 0, MAC, pk(1024, 1024, 0, 0), pk(1024, -256, 0, 0));
        expect_res(pk(7680, -2560, 0, 0), 4'b0000);
        idle(2);

        // MAX with all-negative lanes; srcb is ignored
        beat(1, 0, 0, MAX, pk(-1280, 10, -5, 0), pk(999, 999, 999, 999));
        beat(1, 0, 0, MAX, pk(-512, 30, -5, 0),  pk(999, 999, 999, 999));
        beat(1, 1, 0, MAX, pk(-2048, 20, -5, 0), pk(999, 999, 999, 999));
        expect_res(pk(-512, 30, -5, 0), 4'b0000);
        idle(2);

        // Saturation both ways, plus floor-toward-minus-infinity lanes
        beat(1, 0, 0, MAC, pk(32512, 32512, -1, 3), pk(32512, -32512, 1, 100));
        beat(1, 1, 0, MAC, pk(32512, 32512, -1, 3), pk(32512, -32512, 1, 100));
        expect_res(pk(32767, -32768, -2, 2), 4'b0011);
        idle(2);

        // Back-to-back: MAX window, then SUM window with a mid-window mode change
        beat(1, 0, 0, MAX, pk(5, -7, 1, 0),  '0);
        beat(1, 1, 0, MAX, pk(9, -3, 0, -1), '0);
        expect_res(pk(9, -3, 1, 0), 4'b0000);
        beat(1, 0, 0, SUM, pk(100, -100, 32767, 0), '0);
        beat(1, 0, 0, MAX, pk(200, -100, 32767, 0), '0);
        beat(1, 1, 0, MAX, pk(300, -100, 32767, 0), '0);
        expect_res(pk(600, -300, 32767, 0), 4'b0100);
        idle(2);

        // clr mid-window: no result, psum held, next window starts fresh
        beat(1, 0, 0, SUM, pk(1000, 1000, 1000, 1000), '0);
        beat(1, 0, 0, SUM, pk(1000, 1000, 1000, 1000), '0);
        beat(0, 0, 1, SUM, '0, '0);
        idle(3);
        chk("clr_hold_psum", psum_o, pk(600, -300, 32767, 0));
        chk("clr_hold_ovf", 64'(ovf_o), 64'(4'b0100));
        beat(1, 0, 0, SUM, pk(5, -6, 7, 8), '0);
        beat(1, 1, 0, SUM, pk(6, 6, 6, 6), '0);
        expect_res(pk(11, 0, 13, 14), 4'b0000);
        idle(2);

        // Reserved mode latched at open reports 0
        beat(1, 0, 0, RSV, pk(50, 50, 50, 50), '0);
        beat(1, 1, 0, SUM, pk(50, 50, 50, 50), '0);
        expect_res(pk(0, 0, 0, 0), 4'b0000);
        idle(2);

        // clr + valid + last on an open window: single-element window
        beat(1, 0, 0, SUM, pk(500, 500, 500, 500), '0);
        beat(1, 1, 1, SUM, pk(77, -77, 0, 1), '0);
        expect_res(pk(77, -77, 0, 1), 4'b0000);
        idle(3);

        // Random valid gaps without last, then closed by clr
        for (int i = 0; i < 30; i++)
            beat(1'($urandom_range(0, 1)), 1'b0, 1'b0, 2'($urandom_range(0, 3)),
                 {$urandom, $urandom}, {$urandom, $urandom});
        beat(0, 0, 1, MAC, '0, '0);
        idle(2);

        // Asynchronous reset mid-window
        beat(1, 0, 0, SUM, pk(1234, 1234, 1234, 1234), pk(1, 1, 1, 1));
        beat(1, 0, 0, SUM, pk(1234, 1234, 1234, 1234), pk(1, 1, 1, 1));
        fwd_en = 1'b0;
        idle(1);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_psum", psum_o, '0);
        chk("async_rst_src", srca_o | srcb_o, '0);
        chk("async_rst_ctl", 64'({valid_o, last_o, clr_o, mode_o, psum_valid_o, ovf_o}), '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        idle(2);
        fwd_en = 1'b1;
        idle(3);
        beat(1, 1, 0, SUM, pk(1, 2, 3, 4), '0);
        expect_res(pk(1, 2, 3, 4), 4'b0000);

        idle(6);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_vec.md
# pe_vec

Parametrised multi-lane processing element, the successor to the single-lane conv/maxpool PE. It sits in the systolic array in place of `pe`. Each instance performs `LANES` independent signed fixed-point reductions per window, in one of three modes: MAC (convolution), MAX (max-pool) or SUM (avg-pool numerator). It has explicit valid/last framing, per-lane output saturation and a registered pass-through of operands and control to the neighbouring PE.

## Interface
- `DATA_WIDTH`, 16: signed operand/result width per lane.
- `FRAC_BITS`, 8: fraction bits of the fixed-point format.
- `LANES`, 4: number of independent lanes.
- `ACC_WIDTH`, 2*DATA_WIDTH+8: internal accumulator width per lane.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `valid_i`  in  1  the operand beat on `srca_i`/`srcb_i` is valid.
- `last_i`  in  1  the beat is the final element of the window (qualified by `valid_i`).
- `clr_i`  in  1  synchronous clear of the window state.
- `mode_i`  in  2  00 MAC, 01 MAX, 10 SUM, 11 reserved.
- `srca_i`  in  LANES*DATA_WIDTH  operand A; lane k occupies bits [k*DW +: DW].
- `srcb_i`  in  LANES*DATA_WIDTH  operand B, used in MAC mode only.
- `srca_o`, `srcb_o`  out  LANES*DATA_WIDTH  operands delayed 1 cycle.
- `valid_o`, `last_o`, `clr_o`, `mode_o`  out  1/1/1/2  control delayed 1 cycle.
- `psum_o`  out  LANES*DATA_WIDTH  saturated window result per lane.
- `psum_valid_o`  out  1  one-cycle pulse marking a new `psum_o`.
- `ovf_o`  out  LANES  per-lane saturation flag for the current `psum_o`.

## Operation
- **Reset:** every register and output is 0, the window is closed, and the latched mode is 00.
- **Pass-through:**
  - All `*_o` forwarding outputs register their inputs unconditionally each cycle, including when `valid_i` is 0.
- **Window control:**
  - The first valid beat after reset, after `last`, or after `clr` opens a window.
  - `mode_i` is latched on the opening beat. `mode_i` on later beats of that window is ignored.
- **MAC:**
  - `prod = srca*srcb`, a full 2*DW signed product.
  - The product is arithmetically shifted right by `FRAC_BITS`, i.e. it floors toward -inf.
  - The shifted value is sign-extended to `ACC_WIDTH` and added to the accumulator.
- **SUM:** the accumulator adds `srca` sign-extended to `ACC_WIDTH`.
- **MAX:**
  - On the opening beat the accumulator is loaded with `srca`. It is never compared against 0.
  - On later beats, `acc = max(acc, srca)`, using a signed compare.
- **Opening beat in MAC/SUM:** the accumulator is loaded with the term itself rather than added to the old value.
- **Reserved mode 11:**
  - Valid beats leave the accumulator unchanged.
  - `last` still closes the window and emits `psum`, which is 0 if 11 was latched at open.
- **Saturation:**
  - On `last`, each lane clamps its accumulator to [-2^(DW-1), 2^(DW-1)-1] and writes it to `psum_o`.
  - The lane's `ovf_o` bit is 1 iff clamping occurred.
  - The accumulator itself wraps modulo 2^ACC_WIDTH. The upstream producer is responsible for keeping window length within the guard bits.
- **`clr_i`:**
  - Closes the window and zeroes the accumulators.
  - Does not touch `psum_o`/`ovf_o`, and generates no `psum_valid_o`.
- **Simultaneous events:**
  - `clr_i` with `valid_i`: the clear applies first, and the beat then opens a new window.
  - `clr_i` with `valid_i & last_i`: a single-element window; a result is emitted.
- **Back-to-back windows:** a beat carrying `last` followed immediately by a valid beat is legal and needs no bubble.
- **Holding:** `psum_o`/`ovf_o` hold their value until the next result.

## Timing
- Two-stage pipeline. Control (`valid`, `last`, `clr`, mode) travels with the data so that ordering is preserved.
- **Edge E0** samples the inputs.
- **Edge E1:**
  - Stage 1 registers the per-lane term (shifted product or `srca`) and the control.
  - The forwarding outputs update on this edge (1-cycle latency).
- **Edge E2:**
  - The accumulator updates.
  - If the beat carried `last`, `psum_o`/`ovf_o` update and `psum_valid_o` is high for exactly the cycle after E2, i.e. 2-cycle latency from the `last` beat.
- **Throughput:** one beat per cycle per lane, with no backpressure.
- **Reset asserted mid-window:** all outputs go to 0 immediately (asynchronously). No partial result is emitted after reset is released.

## Test plan
All scenarios use DW=16, FRAC=8, LANES=4.
- **MAC:**
  - Stimulus: lane0 a=b=256,512,768,1024, with `last` on the 4th beat.
  - Required: `psum_o[0]`=7680 and `psum_valid_o` pulse exactly 2 cycles after that beat. Lane1 fed with b=-256 gives -2560. `ovf_o`=0.
- **MAX with negatives:**
  - Stimulus: lane0 a=-1280,-512,-2048.
  - Required: -512, which confirms the first beat is loaded rather than compared with 0.
- **Saturation:**
  - Stimulus: MAC a=b=32512 for 2 beats, and on another lane a=32512, b=-32512.
  - Required: `psum_o`=32767 and -32768 on the respective lanes, with the corresponding `ovf_o` bits set.
- **Back-to-back windows:**
  - Stimulus: a MAX window ends on cycle t. A SUM window (a=100,200,300) opens at t+1, and `mode_i` is switched to 01 mid-window.
  - Required: two `psum_valid_o` pulses, 3 cycles apart, the second giving 600.
- **clr cases:**
  - Stimulus 1: `clr_i` mid-window.
    - Required: no pulse, the previous `psum_o` is held, and the next window is unaffected by earlier beats.
  - Stimulus 2: `clr_i` + `valid_i` + `last_i` with SUM a=77.
    - Required: 77.
- **Forwarding and reset:**
  - Stimulus: random valid gaps.
  - Required: `srca_o`/`srcb_o`/`valid_o`/`last_o`/`clr_o`/`mode_o` equal the inputs delayed 1 cycle.
  - Stimulus: assert `rst_i` between edges mid-window.
  - Required: all outputs 0 before the next edge.
